// File: rtl/rvsteel_wdt.sv
// Watchdog timer peripheral: a down-counter reloaded by a keyed kick.
// The first expiry raises a level bark interrupt; a second expiry while the bark is pending requests a system reset pulse.
module rvsteel_wdt #(
  parameter logic [31:0] DEFAULT_TIMEOUT    = 32'h00FF_FFFF,
  parameter int          RESET_PULSE_CYCLES = 16,
  parameter logic [31:0] KICK_KEY           = 32'h5A5A_5A5A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic        irq,
  output logic        wdt_reset_request
);

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_LOAD   = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_KICK   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  logic [2:0]  ctrl_reg, ctrl_next;
  logic [31:0] load_reg, load_next;
  logic [31:0] count_reg, count_next;
  logic        bark_reg, bark_next;
  logic        bite_reg, bite_next;
  logic [7:0]  pulse_reg, pulse_next;
  logic [31:0] read_data_reg, read_data_next;
  logic        read_response_reg;
  logic        write_response_reg;

  logic [2:0]  word_addr;
  logic        unused_addr_bits;
  logic        wr_ctrl, wr_load, wr_kick, wr_status;
  logic        kick, en_rise, reload, expiry;

  assign word_addr        = rw_address[4:2];
  assign unused_addr_bits = ^rw_address[1:0];

  assign wr_ctrl   = write_request && (word_addr == ADDR_CTRL);
  assign wr_load   = write_request && (word_addr == ADDR_LOAD);
  assign wr_kick   = write_request && (word_addr == ADDR_KICK);
  assign wr_status = write_request && (word_addr == ADDR_STATUS);

  assign kick    = wr_kick && (write_strobe == 4'b1111) && (write_data == KICK_KEY);
  assign en_rise = wr_ctrl && write_strobe[0] && write_data[0] && !ctrl_reg[0];
  assign reload  = kick || en_rise;
  // A reload in the same cycle suppresses the expiry entirely.
  assign expiry  = ctrl_reg[0] && (count_reg == 32'd0) && !reload;

  always_comb begin
    ctrl_next = ctrl_reg;
    if (wr_ctrl && write_strobe[0]) begin
      ctrl_next = write_data[2:0];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_load_byte
      assign load_next[gi*8 +: 8] = (wr_load && write_strobe[gi]) ?
                                    write_data[gi*8 +: 8] : load_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (reload || expiry) begin
      count_next = load_reg;
    end else if (ctrl_reg[0] && (count_reg != 32'd0)) begin
      count_next = count_reg - 32'd1;
    end
  end

  // Software clears first; the expiry, judged on the pre-write BARK, overrides.
  always_comb begin
    bark_next  = bark_reg;
    bite_next  = bite_reg;
    pulse_next = (pulse_reg != 8'd0) ? pulse_reg - 8'd1 : 8'd0;
    if (wr_status && write_strobe[0]) begin
      bark_next = bark_reg & ~write_data[0];
      bite_next = bite_reg & ~write_data[1];
    end
    if (expiry) begin
      if (bark_reg) begin
        bite_next = 1'b1;
        bark_next = 1'b0;
        if (ctrl_reg[2]) begin
          pulse_next = 8'(RESET_PULSE_CYCLES);
        end
      end else begin
        bark_next = 1'b1;
      end
    end
  end

  always_comb begin
    read_data_next = 32'd0;
    if (read_request) begin
      case (word_addr)
        ADDR_CTRL:   read_data_next = {29'd0, ctrl_reg};
        ADDR_LOAD:   read_data_next = load_reg;
        ADDR_COUNT:  read_data_next = count_reg;
        ADDR_STATUS: read_data_next = {30'd0, bite_reg, bark_reg};
        default:     read_data_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_reg           <= 3'd0;
      load_reg           <= DEFAULT_TIMEOUT;
      count_reg          <= DEFAULT_TIMEOUT;
      bark_reg           <= 1'b0;
      bite_reg           <= 1'b0;
      pulse_reg          <= 8'd0;
      read_data_reg      <= 32'd0;
      read_response_reg  <= 1'b0;
      write_response_reg <= 1'b0;
    end else begin
      ctrl_reg           <= ctrl_next;
      load_reg           <= load_next;
      count_reg          <= count_next;
      bark_reg           <= bark_next;
      bite_reg           <= bite_next;
      pulse_reg          <= pulse_next;
      read_data_reg      <= read_data_next;
      read_response_reg  <= read_request;
      write_response_reg <= write_request;
    end
  end

  assign read_data         = read_data_reg;
  assign read_response     = read_response_reg;
  assign write_response    = write_response_reg;
  assign irq               = bark_reg & ctrl_reg[1];
  assign wdt_reset_request = (pulse_reg != 8'd0);

endmodule

// File: tb/tb_rvsteel_wdt.sv
// Directed bench for rvsteel_wdt: register access, bark, bite pulse, kicks, byte writes and reset mid-pulse.
module tb_rvsteel_wdt;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rw_address = 5'd0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = 32'd0;
  logic [3:0]  write_strobe = 4'd0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic        irq;
  logic        wdt_reset_request;

  int checks = 0;
  int errors = 0;
  int rst_cycles = 0;
  bit count_en = 1'b0;

  rvsteel_wdt dut (
    .clock             (clock),
    .reset             (reset),
    .rw_address        (rw_address),
    .read_data         (read_data),
    .read_request      (read_request),
    .read_response     (read_response),
    .write_data        (write_data),
    .write_strobe      (write_strobe),
    .write_request     (write_request),
    .write_response    (write_response),
    .irq               (irq),
    .wdt_reset_request (wdt_reset_request)
  );

  always #5 clock = ~clock;

  // Pulse width measured once per cycle on the falling edge.
  always @(negedge clock) begin
    if (count_en && wdt_reset_request) rst_cycles <= rst_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1'b1;
    @(posedge clock); #1;
    write_request = 1'b0; write_strobe = 4'd0;
    check("write_response", {31'd0, write_response}, 32'd1);
    $display("WR addr=0x%02h data=0x%08h strb=%b", a, d, s);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clock);
    rw_address = a; read_request = 1'b1;
    @(posedge clock); #1;
    read_request = 1'b0;
    check("read_response", {31'd0, read_response}, 32'd1);
    d = read_data;
    $display("RD addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic idle;
    @(posedge clock); #1;
  endtask

  logic [31:0] rd;
  int irq_first, rst_first;
  bit irq_seen;

  initial begin
    // Reset and basic access
    repeat (3) @(posedge clock);
    #1;
    check("rst_outputs", {read_data[0], read_response, write_response, irq, wdt_reset_request}, 32'd0);
    @(negedge clock); reset = 1'b0;
    bus_read(5'h00, rd); check("rst_ctrl", rd, 32'd0);
    bus_read(5'h04, rd); check("rst_load", rd, 32'h00FF_FFFF);
    bus_read(5'h08, rd); check("rst_count", rd, 32'h00FF_FFFF);
    bus_read(5'h10, rd); check("rst_status", rd, 32'd0);
    idle;
    check("rresp_one_cycle", {read_response, read_data}, 33'd0);
    bus_read(5'h18, rd); check("reserved_read", rd, 32'd0);
    bus_read(5'h0C, rd); check("kick_read", rd, 32'd0);
    bus_write(5'h18, 32'hFFFF_FFFF, 4'b1111);
    bus_read(5'h18, rd); check("reserved_write", rd, 32'd0);

    // Bark: COUNT runs 10..0, then reloads to 10 with BARK set
    bus_write(5'h04, 32'd10, 4'b1111);
    bus_write(5'h00, 32'h3, 4'b1111);
    for (int i = 0; i < 12; i++) begin
      bus_read(5'h08, rd);
      check($sformatf("bark_count_%0d", i), rd, (i <= 10) ? 32'(10 - i) : 32'd10);
    end
    check("bark_irq", {31'd0, irq}, 32'd1);
    bus_read(5'h10, rd); check("bark_status", rd, 32'd1);
    bus_write(5'h10, 32'd1, 4'b0001);
    check("bark_clear_irq", {31'd0, irq}, 32'd0);
    bus_write(5'h00, 32'd0, 4'b1111);

    // Bite: bark at edge 6, bite and 16-cycle pulse at edge 12
    bus_write(5'h04, 32'd5, 4'b1111);
    bus_write(5'h10, 32'd3, 4'b0001);
    rst_cycles = 0; count_en = 1'b1;
    bus_write(5'h00, 32'h7, 4'b1111);
    irq_first = 0; rst_first = 0;
    for (int k = 1; k <= 40; k++) begin
      idle;
      if (irq && irq_first == 0) irq_first = k;
      if (wdt_reset_request) begin
        rst_first = k;
        break;
      end
    end
    check("bite_irq_edge", 32'(irq_first), 32'd6);
    check("bite_rst_edge", 32'(rst_first), 32'd12);
    check("bite_irq_low", {31'd0, irq}, 32'd0);
    bus_write(5'h00, 32'd0, 4'b1111);
    bus_read(5'h10, rd); check("bite_status", rd, 32'd2);
    repeat (20) idle;
    count_en = 1'b0;
    check("bite_pulse_width", 32'(rst_cycles), 32'd16);
    check("bite_pulse_done", {31'd0, wdt_reset_request}, 32'd0);
    bus_write(5'h10, 32'd3, 4'b0001);

    // Kicks every 4 cycles keep BARK clear; bad kicks are ignored
    bus_write(5'h04, 32'd8, 4'b1111);
    bus_write(5'h00, 32'h3, 4'b1111);
    irq_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        repeat (3) begin
          idle;
          if (irq) irq_seen = 1'b1;
        end
      end
      bus_write(5'h0C, 32'h5A5A_5A5A, 4'b1111);
      if (irq) irq_seen = 1'b1;
    end
    check("kick_no_bark", {31'd0, irq_seen}, 32'd0);
    irq_first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k % 4 == 1) begin
        rw_address = 5'h0C; write_request = 1'b1;
        write_data   = (k == 5) ? 32'h5A5A_5A5A : 32'h5A5A_5A5B;
        write_strobe = (k == 5) ? 4'b0011 : 4'b1111;
      end
      @(posedge clock); #1;
      write_request = 1'b0; write_strobe = 4'd0;
      if (irq && irq_first == 0) irq_first = k;
    end
    check("bad_kick_bark_edge", 32'(irq_first), 32'd9);
    bus_write(5'h00, 32'd0, 4'b1111);
    bus_write(5'h10, 32'd3, 4'b0001);

    // Kick lands in the COUNT == 0 cycle
    bus_write(5'h00, 32'h3, 4'b1111);
    repeat (8) idle;
    bus_write(5'h0C, 32'h5A5A_5A5A, 4'b1111);
    bus_read(5'h08, rd); check("kick_vs_expiry_count", rd, 32'd8);
    bus_read(5'h10, rd); check("kick_vs_expiry_status", rd, 32'd0);
    bus_write(5'h00, 32'd0, 4'b1111);
    bus_read(5'h08, rd); check("disabled_count", rd, 32'd5);
    bus_read(5'h08, rd); check("disabled_hold", rd, 32'd5);

    // Byte writes
    bus_write(5'h04, 32'h00FF_FFFF, 4'b1111);
    bus_write(5'h04, 32'h00AB_0000, 4'b0100);
    bus_read(5'h04, rd); check("load_byte2", rd, 32'h00AB_FFFF);
    bus_write(5'h00, 32'h7, 4'b0010);
    bus_read(5'h00, rd); check("ctrl_strobe_ignored", rd, 32'd0);

    // LOAD = 0: bark, then bite, then reset asserted mid-pulse
    bus_write(5'h04, 32'd0, 4'b1111);
    bus_write(5'h00, 32'h7, 4'b1111);
    rst_first = 0;
    for (int k = 1; k <= 10; k++) begin
      idle;
      if (wdt_reset_request) begin
        rst_first = k;
        break;
      end
    end
    check("load0_bite_edge", 32'(rst_first), 32'd2);
    @(negedge clock); reset = 1'b1;
    idle;
    check("midpulse_drop", {30'd0, wdt_reset_request, irq}, 32'd0);
    @(negedge clock); reset = 1'b0;
    bus_read(5'h00, rd); check("post_rst_ctrl", rd, 32'd0);
    bus_read(5'h04, rd); check("post_rst_load", rd, 32'h00FF_FFFF);
    bus_read(5'h08, rd); check("post_rst_count", rd, 32'h00FF_FFFF);
    bus_read(5'h10, rd); check("post_rst_status", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
